// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: next-PC select codes,
// operating modes, default trap vector and the legal sequential step sizes.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JAL,
        SEL_JALR,
        SEL_TRAP,
        SEL_MRET
    } sel_t;

    typedef enum logic {
        RUN,
        STALL
    } mode_t;

    localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0010;

    localparam int unsigned PC_STEP_WORD = 1;
    localparam int unsigned PC_STEP_BYTE = 4;

    // Control-flow changes that come from the instruction stream (checked for alignment)
    function automatic logic is_jump(input sel_t s);
        return (s == SEL_BR) || (s == SEL_JAL) || (s == SEL_JALR);
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Combinational next-PC priority mux with misaligned-target detection.
module pc_target_sel
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     PC_STEP  = PC_STEP_WORD,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEFAULT)
) (
    input  logic            trap,
    input  logic            mret,
    input  logic            jalr,
    input  logic            jal,
    input  logic            b,
    input  logic            comp,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] imm_j,
    input  logic [XLEN-1:0] imm_b,
    output sel_t            sel,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    localparam bit BYTE_MODE = (PC_STEP == PC_STEP_BYTE);

    always_comb begin
        sel    = SEL_SEQ;
        target = pc + XLEN'(PC_STEP);
        if (trap) begin
            sel    = SEL_TRAP;
            target = TRAP_VEC;
        end else if (mret) begin
            sel    = SEL_MRET;
            target = epc;
        end else if (jalr) begin
            sel    = SEL_JALR;
            target = rd1 + imm_i;
            if (BYTE_MODE) target[0] = 1'b0;
        end else if (jal) begin
            sel    = SEL_JAL;
            target = pc + imm_j;
        end else if (b && comp) begin
            sel    = SEL_BR;
            target = pc + imm_b;
        end
        // Word-addressed memory has no sub-word alignment to violate
        misaligned = BYTE_MODE && is_jump(sel) && (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: PC, saved trap PC, misalign cause, redirect pulse
// and retired-instruction counter around the pc_target_sel priority mux.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     PC_STEP  = PC_STEP_WORD,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEFAULT),
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_en,
    input  logic             comp,
    input  logic             b,
    input  logic             jal,
    input  logic             jalr,
    input  logic             trap,
    input  logic             mret,
    input  logic [XLEN-1:0]  rd1,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [XLEN-1:0]  imm_j,
    input  logic [XLEN-1:0]  imm_b,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  epc,
    output logic             cause_misalign,
    output logic             redirect,
    output logic [CNT_W-1:0] instret
);

    sel_t             sel;
    mode_t            mode;
    logic [XLEN-1:0]  target;
    logic             misaligned;
    logic [XLEN-1:0]  pc_n;
    logic [XLEN-1:0]  epc_n;
    logic             cause_n;
    logic             redirect_n;
    logic [CNT_W-1:0] instret_n;

    pc_target_sel #(
        .XLEN     (XLEN),
        .PC_STEP  (PC_STEP),
        .TRAP_VEC (TRAP_VEC)
    ) u_sel (
        .trap       (trap),
        .mret       (mret),
        .jalr       (jalr),
        .jal        (jal),
        .b          (b),
        .comp       (comp),
        .pc         (pc),
        .epc        (epc),
        .rd1        (rd1),
        .imm_i      (imm_i),
        .imm_j      (imm_j),
        .imm_b      (imm_b),
        .sel        (sel),
        .target     (target),
        .misaligned (misaligned)
    );

    always_comb begin
        mode       = pc_en ? RUN : STALL;
        pc_n       = pc;
        epc_n      = epc;
        cause_n    = cause_misalign;
        redirect_n = 1'b0;
        instret_n  = instret;
        // Traps and returns are honoured in either mode; only RUN retires instructions
        if (trap || (misaligned && mode == RUN)) begin
            pc_n       = TRAP_VEC;
            epc_n      = pc;
            cause_n    = misaligned;
            redirect_n = 1'b1;
        end else if (mret) begin
            pc_n       = epc;
            redirect_n = 1'b1;
        end else if (mode == RUN) begin
            pc_n       = target;
            redirect_n = is_jump(sel);
            instret_n  = instret + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            epc            <= '0;
            cause_misalign <= 1'b0;
            redirect       <= 1'b0;
            instret        <= '0;
        end else begin
            pc             <= pc_n;
            epc            <= epc_n;
            cause_misalign <= cause_n;
            redirect       <= redirect_n;
            instret        <= instret_n;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: byte-step instance driven from a vector table through a
// scoreboard queue, plus a word-step / 4-bit-counter instance for wrap-around.
module tb_pc_gen;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        cause;
        logic        redirect;
        logic [31:0] instret;
    } out_t;

    typedef struct {
        logic        pc_en, comp, b, jal, jalr, trap, mret;
        logic [31:0] rd1, imm_i, imm_j, imm_b;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_en, comp, b, jal, jalr, trap, mret;
    logic [31:0] rd1, imm_i, imm_j, imm_b;

    logic [31:0] pc4, epc4, inst4;
    logic        cause4, red4;
    logic [31:0] pc1, epc1;
    logic [3:0]  inst1;
    logic        cause1, red1;

    int n_vec = 0;
    int n_bad = 0;
    out_t exp_q[$];
    vec_t vecs[25];

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN     (32),
        .PC_STEP  (4),
        .RESET_PC (32'h0),
        .TRAP_VEC (32'h0000_0010),
        .CNT_W    (32)
    ) dut4 (
        .clk (clk), .rst_n (rst_n), .pc_en (pc_en), .comp (comp), .b (b),
        .jal (jal), .jalr (jalr), .trap (trap), .mret (mret), .rd1 (rd1),
        .imm_i (imm_i), .imm_j (imm_j), .imm_b (imm_b), .pc (pc4), .epc (epc4),
        .cause_misalign (cause4), .redirect (red4), .instret (inst4)
    );

    pc_gen #(
        .XLEN     (32),
        .PC_STEP  (1),
        .RESET_PC (32'h0),
        .TRAP_VEC (32'h0000_0010),
        .CNT_W    (4)
    ) dut1 (
        .clk (clk), .rst_n (rst_n), .pc_en (pc_en), .comp (comp), .b (b),
        .jal (jal), .jalr (jalr), .trap (trap), .mret (mret), .rd1 (rd1),
        .imm_i (imm_i), .imm_j (imm_j), .imm_b (imm_b), .pc (pc1), .epc (epc1),
        .cause_misalign (cause1), .redirect (red1), .instret (inst1)
    );

    function automatic vec_t v(
        input logic en, cp, bb, jl, jr, tr, mr,
        input logic [31:0] r1, ii, ij, ib,
        input logic [31:0] e_pc, e_epc, input logic e_cause, e_red, input logic [31:0] e_ir);
        vec_t t;
        t.pc_en = en; t.comp = cp; t.b = bb; t.jal = jl; t.jalr = jr; t.trap = tr; t.mret = mr;
        t.rd1 = r1; t.imm_i = ii; t.imm_j = ij; t.imm_b = ib;
        t.exp = '{pc: e_pc, epc: e_epc, cause: e_cause, redirect: e_red, instret: e_ir};
        return t;
    endfunction

    task automatic apply_in(input vec_t t);
        pc_en = t.pc_en; comp = t.comp; b = t.b; jal = t.jal; jalr = t.jalr;
        trap = t.trap; mret = t.mret;
        rd1 = t.rd1; imm_i = t.imm_i; imm_j = t.imm_j; imm_b = t.imm_b;
    endtask

    function automatic out_t act4();
        return '{pc: pc4, epc: epc4, cause: cause4, redirect: red4, instret: inst4};
    endfunction

    function automatic out_t act1();
        return '{pc: pc1, epc: epc1, cause: cause1, redirect: red1, instret: {28'h0, inst1}};
    endfunction

    task automatic cmp(input string name, input out_t a, input out_t e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got pc=%h epc=%h cause=%b redirect=%b instret=%h, want pc=%h epc=%h cause=%b redirect=%b instret=%h",
                     name, a.pc, a.epc, a.cause, a.redirect, a.instret,
                     e.pc, e.epc, e.cause, e.redirect, e.instret);
        end
    endtask

    // Drive at negedge, sample 1 time unit after the following posedge
    task automatic step(input vec_t t, input bit use_dut1, input string name);
        @(negedge clk);
        apply_in(t);
        exp_q.push_back(t.exp);
        @(posedge clk);
        #1;
        cmp(name, use_dut1 ? act1() : act4(), exp_q.pop_front());
    endtask

    initial begin
        vec_t idle;
        vec_t seq;
        idle = v(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0);
        seq  = v(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0);
        apply_in(idle);

        //           en cp b jl jr tr mr  rd1       imm_i imm_j         imm_b     pc        epc       ca rd instret
        vecs[0]  = v(1, 0,0,0, 0, 0, 0,  0,        0,    0,            0,        32'h04,   32'h0,    0, 0, 1);
        vecs[1]  = v(1, 0,0,0, 0, 0, 0,  0,        0,    0,            0,        32'h08,   32'h0,    0, 0, 2);
        vecs[2]  = v(1, 0,0,0, 0, 0, 0,  0,        0,    0,            0,        32'h0C,   32'h0,    0, 0, 3);
        vecs[3]  = v(1, 0,0,1, 0, 0, 0,  0,        0,    32'h14,       0,        32'h20,   32'h0,    0, 1, 4);
        vecs[4]  = v(1, 1,1,0, 0, 0, 0,  0,        0,    0,            32'h10,   32'h30,   32'h0,    0, 1, 5);
        vecs[5]  = v(1, 0,0,1, 0, 0, 0,  0,        0,    32'hFFFF_FFF8, 0,       32'h28,   32'h0,    0, 1, 6);
        vecs[6]  = v(1, 0,0,0, 0, 0, 0,  0,        0,    0,            0,        32'h2C,   32'h0,    0, 0, 7);
        vecs[7]  = v(1, 0,1,0, 0, 0, 0,  0,        0,    0,            32'h10,   32'h30,   32'h0,    0, 0, 8);
        vecs[8]  = v(1, 0,0,0, 1, 0, 0,  32'h101,  0,    0,            0,        32'h100,  32'h0,    0, 1, 9);
        vecs[9]  = v(1, 0,0,0, 1, 0, 0,  32'h102,  0,    0,            0,        32'h10,   32'h100,  1, 1, 9);
        vecs[10] = v(1, 0,0,0, 1, 0, 0,  32'h3C,   4,    0,            0,        32'h40,   32'h100,  1, 1, 10);
        vecs[11] = v(0, 0,0,0, 0, 1, 0,  0,        0,    0,            0,        32'h10,   32'h40,   0, 1, 10);
        vecs[12] = v(0, 0,0,0, 0, 0, 0,  0,        0,    0,            0,        32'h10,   32'h40,   0, 0, 10);
        vecs[13] = v(0, 0,0,0, 0, 0, 1,  0,        0,    0,            0,        32'h40,   32'h40,   0, 1, 10);
        for (int i = 14; i < 19; i++)
            vecs[i] = v(0, 0,0,0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 32'h40, 0, 0, 10);
        vecs[19] = v(1, 0,0,0, 0, 0, 1,  0,        0,    0,            0,        32'h40,   32'h40,   0, 1, 10);
        vecs[20] = v(1, 0,0,0, 0, 1, 1,  0,        0,    0,            0,        32'h10,   32'h40,   0, 1, 10);
        vecs[21] = v(1, 0,0,0, 1, 1, 0,  32'h200,  0,    0,            0,        32'h10,   32'h10,   0, 1, 10);
        vecs[22] = v(1, 0,0,1, 0, 0, 0,  0,        0,    32'h2,        0,        32'h10,   32'h10,   1, 1, 10);
        vecs[23] = v(0, 1,1,0, 0, 0, 0,  0,        0,    0,            32'h6,    32'h10,   32'h10,   1, 0, 10);
        vecs[24] = v(1, 0,0,0, 1, 0, 0,  32'h45,   0,    0,            0,        32'h44,   32'h10,   1, 1, 11);

        // Reset state, both instances
        #12;
        cmp("reset_dut4", act4(), '{pc: 32'h0, epc: 32'h0, cause: 1'b0, redirect: 1'b0, instret: 32'h0});
        cmp("reset_dut1", act1(), '{pc: 32'h0, epc: 32'h0, cause: 1'b0, redirect: 1'b0, instret: 32'h0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++)
            step(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Asynchronous reset mid-cycle must clear state before any clock edge
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_reset", act4(), '{pc: 32'h0, epc: 32'h0, cause: 1'b0, redirect: 1'b0, instret: 32'h0});
        @(negedge clk);
        apply_in(idle);
        rst_n = 1'b1;

        // Word-step wrap: jump to all-ones, then 16 sequential steps (17 advances total)
        step(v(1,0,0,0,1,0,0, 32'hFFFF_FFFF,0,0,0, 32'hFFFF_FFFF,0,0,1,1), 1'b1, "wrap_jalr");
        step(v(1,0,0,0,0,0,0, 0,0,0,0, 32'h0,0,0,0,2), 1'b1, "wrap_pc_zero");
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply_in(seq);
            @(posedge clk);
        end
        step(v(1,0,0,0,0,0,0, 0,0,0,0, 32'hF,0,0,0,1), 1'b1, "wrap_instret");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
